// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced line-select decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_n(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/decoder_n.sv
// Combinational binary-to-one-hot decoder with an enable; all-zero when disabled.
module decoder_n
  import decoder_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]         in,
  input  logic                      en,
  output logic [calc_n(ADDR_W)-1:0] onehot
);

  generate
    for (genvar gi = 0; gi < calc_n(ADDR_W); gi++) begin : g_line
      assign onehot[gi] = en && (in == ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder that can also walk every line 0..SCAN_LAST on request.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int SCAN_LAST = (1 << ADDR_W) - 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      enable,
  input  logic                      scan_start,
  output logic [calc_n(ADDR_W)-1:0] out,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      busy,
  output logic                      done
);

  localparam int N = calc_n(ADDR_W);

  generate
    if (SCAN_LAST >= N || SCAN_LAST < 0) begin : g_bad_scan_last
      $error("decoder_seq: SCAN_LAST must lie in 0..2**ADDR_W-1");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] SCAN_LAST_IDX = ADDR_W'(SCAN_LAST);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   index_reg, index_next;
  logic [N-1:0]        out_reg;
  logic [ADDR_W-1:0]   out_addr_reg;
  logic                busy_reg, done_reg;

  logic [ADDR_W-1:0]   dec_addr;
  logic                dec_en;
  logic [N-1:0]        dec_onehot;
  logic                sel_scan;

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    case (state_reg)
      IDLE: begin
        if (scan_start) begin
          state_next = SCAN;
          index_next = '0;
        end
      end
      SCAN: begin
        if (index_reg == SCAN_LAST_IDX) begin
          state_next = DONE;
        end else begin
          index_next = index_reg + ADDR_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        index_next = '0;
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  // The outputs are registered, so the decoder looks at where the FSM is heading.
  always_comb begin
    sel_scan = (state_next == SCAN);
    dec_addr = sel_scan ? index_next : addr;
    dec_en   = sel_scan ? 1'b1 : ((state_reg == IDLE) && enable);
  end

  decoder_n #(
    .ADDR_W(ADDR_W)
  ) u_decoder_n (
    .in    (dec_addr),
    .en    (dec_en),
    .onehot(dec_onehot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      index_reg    <= '0;
      out_reg      <= '0;
      out_addr_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      index_reg    <= index_next;
      out_reg      <= dec_onehot;
      out_addr_reg <= dec_en ? dec_addr : '0;
      busy_reg     <= sel_scan;
      done_reg     <= (state_next == DONE);
    end
  end

  assign out      = out_reg;
  assign out_addr = out_addr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench: two decoder_seq instances (full scan and SCAN_LAST=5) driven by shared stimulus.
module tb_decoder_seq;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] a;
    logic       b;
    logic       d;
  } exp_t;

  localparam int SL[2] = '{7, 5};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] addr = '0;
  logic       enable = 1'b0;
  logic       scan_start = 1'b0;

  logic [7:0] out_a, out_b;
  logic [2:0] out_addr_a, out_addr_b;
  logic       busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  exp_t pend[2][$];
  exp_t sb[2][$];

  always #5 clk = ~clk;

  decoder_seq #(.ADDR_W(3)) dut_a (
    .clk(clk), .reset(reset), .addr(addr), .enable(enable), .scan_start(scan_start),
    .out(out_a), .out_addr(out_addr_a), .busy(busy_a), .done(done_a)
  );

  decoder_seq #(.ADDR_W(3), .SCAN_LAST(5)) dut_b (
    .clk(clk), .reset(reset), .addr(addr), .enable(enable), .scan_start(scan_start),
    .out(out_b), .out_addr(out_addr_b), .busy(busy_b), .done(done_b)
  );

  function automatic exp_t mk(input bit en, input int idx, input bit b, input bit d);
    exp_t e;
    e.o = en ? 8'(1 << idx) : 8'h00;
    e.a = en ? 3'(idx) : 3'd0;
    e.b = b;
    e.d = d;
    return e;
  endfunction

  // Reference: a scan is a fixed script of future outputs; while it plays, inputs don't matter.
  task automatic model_step(input int k, input bit rst, input bit en, input bit ss, input int ad);
    exp_t e;
    if (rst) begin
      pend[k].delete();
      e = mk(0, 0, 0, 0);
    end else if (pend[k].size() > 0) begin
      e = pend[k].pop_front();
    end else if (ss) begin
      for (int i = 0; i <= SL[k]; i++) pend[k].push_back(mk(1, i, 1, 0));
      pend[k].push_back(mk(0, 0, 0, 1));
      pend[k].push_back(mk(0, 0, 0, 0));
      e = pend[k].pop_front();
    end else begin
      e = mk(en, ad, 0, 0);
    end
    sb[k].push_back(e);
  endtask

  task automatic drive(input bit rst, input bit en, input bit ss, input int ad);
    @(negedge clk);
    reset      = rst;
    enable     = en;
    scan_start = ss;
    addr       = 3'(ad);
    model_step(0, rst, en, ss, ad);
    model_step(1, rst, en, ss, ad);
  endtask

  initial begin : monitor
    exp_t got, exp;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (sb[k].size() > 0) begin
          exp = sb[k].pop_front();
          got = (k == 0) ? {out_a, out_addr_a, busy_a, done_a}
                         : {out_b, out_addr_b, busy_b, done_b};
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL outputs dut%0d t=%0t: got out=%02h out_addr=%0d busy=%b done=%b, want out=%02h out_addr=%0d busy=%b done=%b",
                     k, $time, got.o, got.a, got.b, got.d, exp.o, exp.a, exp.b, exp.d);
          end else begin
            $display("ok dut%0d t=%0t out=%02h out_addr=%0d busy=%b done=%b",
                     k, $time, got.o, got.a, got.b, got.d);
          end
          checks++;
          if ($countones(got.o) > 1) begin
            errors++;
            $display("FAIL onehot dut%0d t=%0t: got out=%02h, want at most one bit set", k, $time, got.o);
          end
        end
      end
    end
  end

  initial begin : stimulus
    // Reset for two cycles, then a plain decode and release.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 5);
    drive(0, 0, 0, 0);
    // Full scan with enable/addr toggling during it.
    drive(0, 0, 1, 0);
    for (int i = 0; i < 11; i++) drive(0, i[0], 0, i % 8);
    // Scan wins over a simultaneous decode request.
    drive(0, 1, 1, 3);
    for (int i = 0; i < 4; i++) drive(0, 1, i == 2, 6);
    // Reset while out=0x10 aborts the scan; then decode addr 2.
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 2);
    drive(0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0), $urandom_range(0, 7));
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (sb[k].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d unchecked entries, want 0", k, sb[k].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
